// File: rtl/rails_pkg.sv
// -----------------------------------------------------------------------------
// rails_pkg
// Shared definitions for the rails permutation checker front end: the train
// entry nibble type, the largest legal train count, the feeder state encoding
// and a helper that decides whether a header train count is acceptable.
// No ports (package).
// -----------------------------------------------------------------------------
package rails_pkg;

   // Largest train count a case may carry; legal counts are 1..MAX_TRAINS.
   localparam int MAX_TRAINS = 10;

   // One order entry (and the train count) travels as a 4-bit nibble.
   typedef logic [3:0] train_t;

   // Feeder FSM encoding, kept as plain constants so older tools and the
   // downstream checker bench can share the same values.
   typedef logic [2:0] state_t;
   localparam state_t IDLE      = 3'd0;
   localparam state_t LOAD      = 3'd1;
   localparam state_t SEND_NUM  = 3'd2;
   localparam state_t SEND_DATA = 3'd3;
   localparam state_t WAIT_RES  = 3'd4;
   localparam state_t REJECT    = 3'd5;

   // A header count is usable only when it is nonzero and fits the buffer.
   function automatic logic n_legal(input train_t n, input train_t max_n);
      return (n != 4'd0) && (n <= max_n);
   endfunction

endpackage

// File: rtl/rails_case_buf.sv
// -----------------------------------------------------------------------------
// rails_case_buf
// Small register file holding one packed test case: DEPTH entries of 8 bits,
// each entry carrying order1 in [3:0] and order2 in [7:4]. One synchronous
// write port and one asynchronous read port. Out-of-range indices are ignored
// on write and read back as zero.
// Ports:
//   clk      system clock, rising edge
//   reset    synchronous active-high clear of all entries
//   wr_en    write enable
//   wr_idx   write index
//   wr_data  entry byte to store
//   rd_idx   read index
//   rd_data  entry byte at rd_idx (combinational)
// -----------------------------------------------------------------------------
import rails_pkg::*;

module rails_case_buf #(
   parameter int DEPTH = MAX_TRAINS,
   parameter int IDX_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [7:0]       wr_data,
   input  logic [IDX_W-1:0] rd_idx,
   output logic [7:0]       rd_data
);

   logic [7:0] mem [DEPTH];

   // Storage: cleared on reset so a discarded partial case leaves no residue.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (wr_en && (int'(wr_idx) < DEPTH)) begin
         mem[wr_idx] <= wr_data;
      end
   end

   // Async read; the guard keeps an out-of-range index from reading past the end.
   always_comb begin
      rd_data = '0;
      if (int'(rd_idx) < DEPTH) begin
         rd_data = mem[rd_idx];
      end
   end

endmodule

// File: rtl/rails_feeder.sv
// -----------------------------------------------------------------------------
// rails_feeder
// Upstream stage for the rails permutation checker. Collects one test case
// (header byte with the train count N, then N entry bytes) from a byte-wide
// valid/ready stream, replays it to the checker as one number cycle followed
// by N contiguous data cycles, then waits for the checker result. The result
// is latched and announced with a one-cycle done pulse; good results also bump
// a wrapping case counter. Bad headers and checker timeouts finish with err.
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous active-high reset
//   in_valid     upstream byte valid
//   in_data      upstream byte (header: [3:0]=N; entry: [3:0]=order1, [7:4]=order2)
//   in_ready     feeder accepts a byte this cycle
//   number       train count to the checker, nonzero only in the number cycle
//   data1        order1 entry to the checker during data cycles, else 0
//   data2        order2 entry to the checker during data cycles, else 0
//   rails_valid  checker result valid
//   rails_res1   checker result1
//   rails_res2   checker result2
//   done         one-cycle pulse when a case finishes
//   res1         latched result1 of the last good case
//   res2         latched result2 of the last good case
//   err          last case was rejected or timed out
//   case_cnt     number of cases finished with a real result (wraps)
// -----------------------------------------------------------------------------
import rails_pkg::*;

module rails_feeder #(
   parameter int MAX_TRAINS = rails_pkg::MAX_TRAINS,
   parameter int TIMEOUT    = 64,
   parameter int CNT_W      = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [7:0]       in_data,
   output logic             in_ready,
   output logic [3:0]       number,
   output logic [3:0]       data1,
   output logic [3:0]       data2,
   input  logic             rails_valid,
   input  logic             rails_res1,
   input  logic             rails_res2,
   output logic             done,
   output logic             res1,
   output logic             res2,
   output logic             err,
   output logic [CNT_W-1:0] case_cnt
);

   localparam int     TMR_W = $clog2(TIMEOUT + 1);
   localparam train_t MAX_N = train_t'(MAX_TRAINS);

   state_t             state;
   train_t             n_reg;
   logic [3:0]         idx;
   logic [TMR_W-1:0]   timer;
   logic               transfer;
   logic               last_entry;
   logic               buf_wr;
   logic [7:0]         buf_rd;
   train_t             hdr_n;

   assign transfer   = in_valid && in_ready;
   assign hdr_n      = in_data[3:0];
   assign last_entry = (idx == (n_reg - 4'd1));
   assign buf_wr     = (state == LOAD) && transfer;

   rails_case_buf #(
      .DEPTH (MAX_TRAINS),
      .IDX_W (4)
   ) u_buf (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (buf_wr),
      .wr_idx  (idx),
      .wr_data (in_data),
      .rd_idx  (idx),
      .rd_data (buf_rd)
   );

   // The stream is only open while collecting a header or entries; everything
   // after the last entry holds the upstream off until the case finishes.
   always_comb begin
      in_ready = (state == IDLE) || (state == LOAD);
   end

   // Checker-facing frame is decoded straight from the state so it drops to
   // zero the cycle after any reset or state change. During data cycles the
   // same idx that addressed the buffer during loading now walks it for replay.
   always_comb begin
      number = '0;
      data1  = '0;
      data2  = '0;
      if (state == SEND_NUM) begin
         number = n_reg;
      end
      if (state == SEND_DATA) begin
         data1 = buf_rd[3:0];
         data2 = buf_rd[7:4];
      end
   end

   // Main sequencer. done defaults low so every finishing path produces a
   // single-cycle pulse. In WAIT_RES a checker valid takes priority over the
   // timeout landing in the same cycle; rails_valid in any other state is
   // simply never looked at, which discards stale results.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         n_reg    <= '0;
         idx      <= '0;
         timer    <= '0;
         done     <= 1'b0;
         res1     <= 1'b0;
         res2     <= 1'b0;
         err      <= 1'b0;
         case_cnt <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (transfer) begin
                  idx <= '0;
                  if (n_legal(hdr_n, MAX_N)) begin
                     n_reg <= hdr_n;
                     state <= LOAD;
                  end else begin
                     state <= REJECT;
                  end
               end
            end

            LOAD: begin
               if (transfer) begin
                  if (last_entry) begin
                     idx   <= '0;
                     state <= SEND_NUM;
                  end else begin
                     idx <= idx + 4'd1;
                  end
               end
            end

            SEND_NUM: begin
               idx   <= '0;
               state <= SEND_DATA;
            end

            SEND_DATA: begin
               if (last_entry) begin
                  idx   <= '0;
                  timer <= '0;
                  state <= WAIT_RES;
               end else begin
                  idx <= idx + 4'd1;
               end
            end

            WAIT_RES: begin
               if (rails_valid) begin
                  res1     <= rails_res1;
                  res2     <= rails_res2;
                  err      <= 1'b0;
                  done     <= 1'b1;
                  case_cnt <= case_cnt + CNT_W'(1);
                  state    <= IDLE;
               end else if (timer >= TMR_W'(TIMEOUT - 1)) begin
                  err   <= 1'b1;
                  done  <= 1'b1;
                  state <= IDLE;
               end else if (timer < TMR_W'(TIMEOUT)) begin
                  timer <= timer + TMR_W'(1);
               end
            end

            REJECT: begin
               err   <= 1'b1;
               done  <= 1'b1;
               state <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rails_feeder.sv
// -----------------------------------------------------------------------------
// tb_rails_feeder
// Self-checking bench for rails_feeder. A table of cases is streamed in; each
// case pushes its expected frame and expected completion onto queues that the
// frame monitor (which also plays the checker) and the done monitor pop.
// Hand-written sequences cover gaps in the stream, timeout, mid-case reset and
// case counter wrap.
// -----------------------------------------------------------------------------
module tb_rails_feeder;

   localparam int TIMEOUT = 64;
   localparam int CNT_W   = 8;

   logic             clk = 1'b0;
   logic             reset;
   logic             in_valid;
   logic [7:0]       in_data;
   logic             in_ready;
   logic [3:0]       number;
   logic [3:0]       data1;
   logic [3:0]       data2;
   logic             rails_valid;
   logic             rails_res1;
   logic             rails_res2;
   logic             done;
   logic             res1;
   logic             res2;
   logic             err;
   logic [CNT_W-1:0] case_cnt;

   logic model_valid = 1'b0;
   logic stale_valid = 1'b0;
   assign rails_valid = model_valid | stale_valid;

   always #5 clk = ~clk;

   rails_feeder #(
      .MAX_TRAINS (10),
      .TIMEOUT    (TIMEOUT),
      .CNT_W      (CNT_W)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .in_ready    (in_ready),
      .number      (number),
      .data1       (data1),
      .data2       (data2),
      .rails_valid (rails_valid),
      .rails_res1  (rails_res1),
      .rails_res2  (rails_res2),
      .done        (done),
      .res1        (res1),
      .res2        (res2),
      .err         (err),
      .case_cnt    (case_cnt)
   );

   // One test case: header, up to ten entries (e[0] first), checker latency
   // (negative means the checker never answers) and the checker's results.
   typedef struct {
      logic [7:0]      hdr;
      int              n;
      logic [9:0][7:0] e;
      int              lat;
      logic            r1;
      logic            r2;
   } case_t;

   typedef struct packed {
      logic       err;
      logic       r1;
      logic       r2;
      logic [7:0] cnt;
   } result_t;

   case_t   frame_q[$];
   result_t exp_q[$];

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] model_cnt = '0;
   logic       model_r1  = 1'b0;
   logic       model_r2  = 1'b0;

   case_t tbl[7];

   function automatic case_t mk(input logic [7:0] hdr, input logic [79:0] e,
                                input int lat, input logic r1, input logic r2);
      case_t c;
      c.hdr = hdr;
      c.n   = int'(hdr[3:0]);
      c.e   = e;
      c.lat = lat;
      c.r1  = r1;
      c.r2  = r2;
      return c;
   endfunction

   task automatic check_output(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Offer one byte and hold it until a transfer happens (bounded).
   task automatic send_byte(input logic [7:0] b);
      logic acc;
      acc      = 1'b0;
      in_valid = 1'b1;
      in_data  = b;
      for (int t = 0; t < 300; t++) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         if (acc) break;
      end
      check_output("byte_accepted_within_bound", acc, 1);
      in_valid = 1'b0;
      in_data  = 8'hEE;
   endtask

   // Push expectations for a case, then stream it with optional idle gaps.
   task automatic apply_stimulus(input case_t c, input int gap);
      result_t r;
      logic    legal;
      legal = (c.n >= 1) && (c.n <= 10);
      if (legal) begin
         frame_q.push_back(c);
         if (c.lat < 0) begin
            r = '{err: 1'b1, r1: model_r1, r2: model_r2, cnt: model_cnt};
         end else begin
            model_cnt = model_cnt + 8'd1;
            model_r1  = c.r1;
            model_r2  = c.r2;
            r = '{err: 1'b0, r1: model_r1, r2: model_r2, cnt: model_cnt};
         end
      end else begin
         r = '{err: 1'b1, r1: model_r1, r2: model_r2, cnt: model_cnt};
      end
      exp_q.push_back(r);
      send_byte(c.hdr);
      if (legal) begin
         for (int k = 0; k < c.n; k++) begin
            if (k > 0) begin
               repeat (gap) begin
                  @(posedge clk);
                  #1;
               end
            end
            send_byte(c.e[k]);
         end
      end
   endtask

   task automatic wait_drain();
      for (int t = 0; t < 3000; t++) begin
         if (exp_q.size() == 0 && frame_q.size() == 0) break;
         @(posedge clk);
         #1;
      end
      check_output("queues_drained", exp_q.size() + frame_q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   // Frame monitor and checker model: verifies the number cycle, the N
   // contiguous data cycles and the quiet WAIT_RES cycle, then answers.
   initial begin
      case_t f;
      int    got;
      bit    aborted;
      rails_res1 = 1'b0;
      rails_res2 = 1'b0;
      forever begin
         @(negedge clk);
         if (!reset && number != 4'd0) begin
            if (frame_q.size() == 0) begin
               check_output("unexpected_frame_number", number, 0);
            end else begin
               f = frame_q.pop_front();
               check_output("frame_number", number, f.n);
               check_output("in_ready_send_num", in_ready, 0);
               aborted = 1'b0;
               for (int k = 0; k < f.n; k++) begin
                  @(negedge clk);
                  if (reset) begin
                     aborted = 1'b1;
                     break;
                  end
                  check_output($sformatf("frame_data_k%0d", k), {number, data2, data1},
                               {4'd0, f.e[k][7:4], f.e[k][3:0]});
                  check_output("in_ready_send_data", in_ready, 0);
               end
               if (!aborted) begin
                  @(negedge clk);
                  check_output("frame_end_quiet", {number, data2, data1}, 0);
                  check_output("in_ready_wait_res", in_ready, 0);
                  if (f.lat < 0) begin
                     got = 0;
                     for (int i = 1; i <= TIMEOUT + 8; i++) begin
                        @(negedge clk);
                        if (done) begin
                           got = i;
                           break;
                        end
                     end
                     check_output("timeout_latency", got, TIMEOUT);
                  end else begin
                     repeat (f.lat) @(negedge clk);
                     rails_res1  = f.r1;
                     rails_res2  = f.r2;
                     model_valid = 1'b1;
                     @(negedge clk);
                     model_valid = 1'b0;
                     rails_res1  = 1'b0;
                     rails_res2  = 1'b0;
                  end
               end
            end
         end
      end
   end

   // Done monitor: every done pulse must match the oldest expected outcome.
   initial begin
      result_t r;
      forever begin
         @(negedge clk);
         if (!reset && done) begin
            if (exp_q.size() == 0) begin
               check_output("unexpected_done", done, 0);
            end else begin
               r = exp_q.pop_front();
               check_output("done_result_err_r1_r2_cnt", {err, res1, res2, case_cnt},
                            {r.err, r.r1, r.r2, r.cnt});
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog expired actual=running required=finished");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      tbl[0] = mk(8'h03, 80'h12_21_33, 0, 1'b1, 1'b0);
      tbl[1] = mk(8'h00, 80'h0, 0, 1'b0, 1'b0);
      tbl[2] = mk(8'h0B, 80'h0, 0, 1'b0, 1'b0);
      tbl[3] = mk(8'h0A, 80'hA9_87_65_43_21_12_34_56_78_9A, 3, 1'b0, 1'b1);
      tbl[4] = mk(8'h71, 80'h5A, 1, 1'b1, 1'b1);
      tbl[5] = mk(8'hFF, 80'h0, 0, 1'b0, 1'b0);
      tbl[6] = mk(8'h02, 80'h9E_FF, 2, 1'b0, 1'b0);

      reset    = 1'b1;
      in_valid = 1'b0;
      in_data  = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check_output("reset_outputs", {done, err, res1, res2, case_cnt, number, data1, data2}, 0);
      check_output("reset_in_ready", in_ready, 1);

      // Stale checker valid while idle must not finish anything.
      @(posedge clk);
      #1;
      stale_valid = 1'b1;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      stale_valid = 1'b0;
      check_output("stale_valid_no_done", done, 0);

      $display("[TB] table cases");
      for (int i = 0; i < 7; i++) begin
         apply_stimulus(tbl[i], 0);
      end
      wait_drain();
      check_output("case_cnt_after_table", case_cnt, model_cnt);

      $display("[TB] gapped N=4 case");
      apply_stimulus(mk(8'h04, 80'h14_23_32_41, 2, 1'b0, 1'b1), 3);
      wait_drain();

      $display("[TB] timeout then recovery");
      apply_stimulus(mk(8'h02, 80'h21_12, -1, 1'b0, 1'b0), 0);
      apply_stimulus(mk(8'h01, 80'h77, 0, 1'b1, 1'b1), 0);
      wait_drain();
      check_output("err_cleared_after_recovery", err, 0);

      $display("[TB] reset during SEND_DATA");
      apply_stimulus(mk(8'h05, 80'h51_42_33_24_15, 0, 1'b1, 1'b0), 0);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      frame_q.delete();
      exp_q.delete();
      model_cnt = '0;
      model_r1  = 1'b0;
      model_r2  = 1'b0;
      check_output("mid_reset_outputs", {done, err, res1, res2, case_cnt, number, data1, data2}, 0);
      reset = 1'b0;
      apply_stimulus(mk(8'h01, 80'h11, 0, 1'b0, 1'b1), 0);
      wait_drain();
      check_output("case_cnt_after_reset_case", case_cnt, 1);

      $display("[TB] back-to-back N=1 cases to wrap the counter");
      for (int i = 0; i < 255; i++) begin
         logic [7:0] ib;
         ib = 8'(i);
         apply_stimulus(mk(8'h01, {72'h0, ib}, i % 3, ib[0], ib[1]), 0);
      end
      wait_drain();
      check_output("case_cnt_wrap", case_cnt, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/rails_feeder.md
Name: rails_feeder

Overview:
Upstream stage for the rails permutation checker. It accepts packed test cases from a byte-wide valid/ready stream and buffers one complete case. It then replays the case onto the checker's number/data1/data2 inputs with fixed frame timing. Finally it waits for the checker's valid, latches result1/result2, and reports them with a done pulse and a running case count.

Parameters:
MAX_TRAINS, 10, largest legal train count; valid N is 1..MAX_TRAINS.
TIMEOUT, 64, cycles allowed in WAIT_RES before the case is abandoned.
CNT_W, 8, width of the case counter.

Ports:
clk  input  1  system clock; all logic on the rising edge.
reset  input  1  synchronous, active-high reset.
in_valid  input  1  byte on in_data is valid.
in_data  input  8  header byte: [3:0]=N, [7:4] ignored. Entry byte: [3:0]=order1 entry, [7:4]=order2 entry.
in_ready  output  1  feeder accepts a byte this cycle.
number  output  4  train count to checker; nonzero only in the SEND_NUM cycle.
data1  output  4  order-1 entry to checker during SEND_DATA, else 0.
data2  output  4  order-2 entry to checker during SEND_DATA, else 0.
rails_valid  input  1  valid output of the checker.
rails_res1  input  1  result1 of the checker.
rails_res2  input  1  result2 of the checker.
done  output  1  one-cycle pulse when a case finishes (result, error or timeout).
res1  output  1  latched result1 of the last case.
res2  output  1  latched result2 of the last case.
err  output  1  last case was rejected (bad N) or timed out; held until the next done.
case_cnt  output  CNT_W  count of cases that completed with a real result; wraps modulo 2^CNT_W.

Behaviour:
- A byte transfers when in_valid && in_ready.
- Reset values: all outputs 0, state IDLE, buffer index 0.
- States and transitions:
  - IDLE: in_ready=1. A header transfer with 1<=N<=MAX_TRAINS latches N and goes to LOAD. A header with N=0 or N>MAX_TRAINS goes to REJECT.
  - LOAD: in_ready=1. Each transfer writes entry[idx] and increments idx. When the Nth entry transfers, go to SEND_NUM next cycle.
  - SEND_NUM: exactly 1 cycle; number=N, data=0, in_ready=0.
  - SEND_DATA: exactly N cycles; cycle k (0-based) drives data1=entry[k][3:0], data2=entry[k][7:4], number=0. Entries go out with no gaps.
  - WAIT_RES: outputs 0. On rails_valid: latch res1/res2 from rails_res1/2, clear err, pulse done, increment case_cnt, go to IDLE. If TIMEOUT cycles elapse first: set err=1, pulse done, leave res1/res2 and case_cnt unchanged, go to IDLE.
  - REJECT: 1 cycle; set err=1, pulse done, go to IDLE. No frame is sent and case_cnt is unchanged.
- Latency: the first number cycle comes 1 cycle after the last entry transfer. From the header transfer, the shortest path to done is N+N+1+1+checker latency cycles.
- rails_valid outside WAIT_RES is ignored, including stale valid from the previous case.
- in_valid while in_ready=0 is not consumed; the upstream holds the byte.
- Entry nibbles are passed through unchecked; range checking belongs to the checker.
- Timeout counter is zeroed on entry to WAIT_RES and saturates.
- A new case may start in IDLE the cycle after done.
- Reset mid-operation: the partial buffer is discarded, counters and case_cnt clear, and outputs go to 0 next cycle.

Decomposition:
- Shared package rails_pkg: state enum (IDLE, LOAD, SEND_NUM, SEND_DATA, WAIT_RES, REJECT), MAX_TRAINS, nibble typedef train_t (4 bits).
- One natural sub-module: rails_case_buf, a MAX_TRAINS x 8 register file with write index/enable and an async read port, reused by the downstream checker testbench.

Test Plan:
- Stream header 0x03 then entries 0x33, 0x21, 0x12 -> number=3 for 1 cycle, then (data1,data2) = (3,3),(1,2),(2,1) on consecutive cycles. With the model asserting valid, res1=1, res2=0 -> done pulse, res1=1, res2=0, case_cnt=1, err=0.
- Header 0x00, then header 0x0B -> two done pulses with err=1, no number/data activity, case_cnt unchanged.
- Drop in_valid for 3 cycles between entries of an N=4 case -> the frame is still sent contiguous, exactly 4 data cycles after the number cycle.
- Checker model never asserts valid -> done with err=1 exactly TIMEOUT=64 cycles after entering WAIT_RES. The next case runs normally and clears err.
- Assert reset 2 cycles into SEND_DATA of an N=5 case -> outputs 0 next cycle, case_cnt=0. A following N=1 case (0x01, 0x11) sends number=1 then data (1,1).
- Back-to-back 256 cases with N=1 -> case_cnt wraps to 0, and in_ready deasserts during every SEND/WAIT phase.
